fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction fetch sequencer for the microcoded accumulator CPU. It owns the program counter and drives the combinational program ROM address. It registers the returned 16-bit word into a one-entry instruction register and hands it to the microcode decoder over a valid/ready handshake. It also handles jump redirects, halt-word detection and resume.

## Interface

- RESET_PC, 8'h00, program counter value after reset.
- HALT_WORD, 16'hffff, ROM word that stops fetching; it is never issued to the decoder.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_out  out  8  ROM address; equals internal pc register.
- rom_data  in  16  ROM word at pc_out, combinational from ROM, same cycle.
- ir  out  16  issued instruction.
- ir_pc  out  8  address ir was fetched from.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decoder accepts ir this cycle.
- jump_valid  in  1  redirect request; consumes the current ir.
- jump_addr  in  8  redirect target.
- resume  in  1  single-cycle pulse; leaves HALTED.
- halted  out  1  high while in HALTED.

## Operation

- States: FETCH, VALID, HALTED. Reset enters FETCH.
- Reset values:
  - pc = RESET_PC
  - ir = 16'h0000, ir_pc = 8'h00
  - ir_valid = 0, halted = 0
- Priority in every state: jump_valid over resume over ir_ready.
- FETCH:
  - jump_valid: pc <= jump_addr; stay in FETCH.
  - rom_data == HALT_WORD: go to HALTED; pc unchanged; ir_valid stays 0.
  - Otherwise: ir <= rom_data, ir_pc <= pc, pc <= pc+1, ir_valid <= 1; go to VALID.
- VALID:
  - jump_valid: ir_valid <= 0, pc <= jump_addr; go to FETCH. ir_ready is ignored.
  - ir_ready, rom_data != HALT_WORD: load ir/ir_pc from rom_data/pc, pc <= pc+1; stay in VALID. Back-to-back issue.
  - ir_ready, rom_data == HALT_WORD: ir_valid <= 0; go to HALTED; pc unchanged (points at halt word).
  - Neither: hold ir, ir_pc, pc.
- HALTED:
  - halted = 1; ir_valid = 0.
  - jump_valid: pc <= jump_addr; go to FETCH.
  - resume: pc <= pc+1; go to FETCH.
  - Otherwise hold.
- PC arithmetic is 8-bit modulo 256: 8'hff + 1 = 8'h00. No wrap flag.
- rom_data is sampled only in FETCH, or in VALID when ir_ready=1. It is ignored otherwise.
- ir_pc + 1 is the fall-through address the decoder uses for relative logic. jump_addr is absolute.

## Timing

- pc_out is registered. The ROM path pc_out -> rom_data -> ir is one combinational path within a single cycle.
- Reset deassert to first ir_valid: 1 cycle (FETCH at RESET_PC on the first edge).
- Steady-state issue rate: 1 instruction per cycle while ir_ready=1.
- Jump penalty: 1 bubble cycle. ir_valid is low in the cycle after jump_valid. The target instruction is valid the cycle after that.
- Halt detection: halted rises on the edge that would have issued the halt word. No instruction is issued that cycle.
- resume to next ir_valid: 2 cycles. jump_valid from HALTED to ir_valid: 2 cycles.
- Asynchronous reset mid-operation: all outputs take reset values immediately, regardless of clk. The in-flight ir is discarded.
- jump_valid asserted while ir_valid=0 in FETCH redirects with no issue. No instruction from the old pc is ever presented.

## Test plan

- Reset, ir_ready=1, standard ROM image: ir sequence 7f00@00, 0100@01, 0101@02, 7200@03 on consecutive cycles; ir_valid first high 1 cycle after reset release.
- Backpressure: ir_ready=0 for 3 cycles while ir=0101@02 -> ir, ir_pc and pc_out=03 held constant; release -> 7200@03 next cycle.
- Jump: while ir=0303@0b, pulse jump_valid with jump_addr=03 -> ir_valid=0 for one cycle, then ir=7200, ir_pc=03, pc_out=04.
- Halt/resume: jump to 0x0d (ROM default ffff) -> halted=1, ir_valid=0, pc_out=0d held for 10 cycles; jump_valid to 00 -> halted=0, ir=7f00@00 two cycles later.
- Wrap: stub ROM returning 1234 everywhere, jump to ff -> ir=1234@ff, then ir_pc=00, pc_out=01.
- Async reset: assert rst_n=0 mid-cycle during back-to-back issue -> ir_valid=0, pc_out=00, halted=0 before next edge; release -> 7f00@00 restarts.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch bus between the fetch sequencer, the program ROM and the microcode decoder.
interface fetch_if;
  logic [7:0]  pc_out;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_valid;
  logic [7:0]  jump_addr;
  logic        resume;
  logic        halted;

  modport master (
    output pc_out, ir, ir_pc, ir_valid, halted,
    input  rom_data, ir_ready, jump_valid, jump_addr, resume
  );

  modport slave (
    input  pc_out, ir, ir_pc, ir_valid, halted,
    output rom_data, ir_ready, jump_valid, jump_addr, resume
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, registers ROM words into a one-entry
// instruction register, and handles jump redirects, halt-word detection and resume.
//
// state  | meaning
// FETCH  | ir empty; sample rom_data at pc and issue it (or halt)
// VALID  | ir holds an unconsumed instruction for the decoder
// HALTED | halt word seen at pc; waiting for resume or jump
module fetch_ctrl #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'hffff
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, VALID, HALTED} state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        is_halt;

  assign is_halt = (bus.rom_data == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      ir_pc    <= 8'h00;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.jump_valid) begin
            pc <= bus.jump_addr;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else begin
            ir       <= bus.rom_data;
            ir_pc    <= pc;
            pc       <= pc + 8'd1;
            ir_valid <= 1'b1;
            state    <= VALID;
          end
        end
        VALID: begin
          if (bus.jump_valid) begin
            ir_valid <= 1'b0;
            pc       <= bus.jump_addr;
            state    <= FETCH;
          end else if (bus.ir_ready) begin
            if (is_halt) begin
              // pc stays on the halt word so resume steps past it
              ir_valid <= 1'b0;
              halted   <= 1'b1;
              state    <= HALTED;
            end else begin
              ir    <= bus.rom_data;
              ir_pc <= pc;
              pc    <= pc + 8'd1;
            end
          end
        end
        HALTED: begin
          if (bus.jump_valid) begin
            pc     <= bus.jump_addr;
            halted <= 1'b0;
            state  <= FETCH;
          end else if (bus.resume) begin
            pc     <= pc + 8'd1;
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: begin
          ir_valid <= 1'b0;
          halted   <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

  assign bus.pc_out   = pc;
  assign bus.ir       = ir;
  assign bus.ir_pc    = ir_pc;
  assign bus.ir_valid = ir_valid;
  assign bus.halted   = halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural program ROM.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;
  logic stub;
  logic [15:0] rom [256];
  int total;
  int bad;

  fetch_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.rom_data = stub ? 16'h1234 : rom[bus.pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string tag, input logic [15:0] e_ir, input logic [7:0] e_pc,
                           input logic [7:0] e_next);
    chk({tag, "_valid"}, {31'd0, bus.ir_valid}, 32'd1);
    chk({tag, "_ir"}, {16'd0, bus.ir}, {16'd0, e_ir});
    chk({tag, "_irpc"}, {24'd0, bus.ir_pc}, {24'd0, e_pc});
    chk({tag, "_pc"}, {24'd0, bus.pc_out}, {24'd0, e_next});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    stub  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hffff;
    rom[0] = 16'h7f00;
    rom[1] = 16'h0100;
    rom[2] = 16'h0101;
    rom[3] = 16'h7200;
    for (int i = 4; i < 13; i++) rom[i] = 16'h0200 + 16'(i);
    rom[11] = 16'h0303;

    rst_n          = 1'b0;
    bus.ir_ready   = 1'b1;
    bus.jump_valid = 1'b0;
    bus.jump_addr  = 8'h00;
    bus.resume     = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_pc", {24'd0, bus.pc_out}, 32'h00);
    chk("rst_ir", {16'd0, bus.ir}, 32'h0000);
    chk("rst_irpc", {24'd0, bus.ir_pc}, 32'h00);

    // streaming issue
    rst_n = 1'b1;
    tick(); chk_issue("s0", 16'h7f00, 8'h00, 8'h01);
    tick(); chk_issue("s1", 16'h0100, 8'h01, 8'h02);
    tick(); chk_issue("s2", 16'h0101, 8'h02, 8'h03);

    // backpressure
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_issue("hold", 16'h0101, 8'h02, 8'h03);
    end
    bus.ir_ready = 1'b1;
    tick(); chk_issue("s3", 16'h7200, 8'h03, 8'h04);
    for (int i = 4; i < 11; i++) tick();
    chk_issue("s10", 16'h020a, 8'h0a, 8'h0b);
    tick(); chk_issue("s11", 16'h0303, 8'h0b, 8'h0c);

    // jump from VALID: one bubble, then target
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'h03;
    tick();
    chk("jmp_bubble", {31'd0, bus.ir_valid}, 32'd0);
    chk("jmp_pc", {24'd0, bus.pc_out}, 32'h03);
    bus.jump_valid = 1'b0;
    bus.ir_ready   = 1'b0;
    tick(); chk_issue("jmp_tgt", 16'h7200, 8'h03, 8'h04);

    // jump onto the halt word
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'h0d;
    tick();
    chk("h_bubble", {31'd0, bus.ir_valid}, 32'd0);
    bus.jump_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("h_halted", {31'd0, bus.halted}, 32'd1);
      chk("h_valid", {31'd0, bus.ir_valid}, 32'd0);
      chk("h_pc", {24'd0, bus.pc_out}, 32'h0d);
    end

    // resume steps past the halt word; 0e is also a halt word
    bus.resume = 1'b1;
    tick();
    chk("res_halted", {31'd0, bus.halted}, 32'd0);
    chk("res_pc", {24'd0, bus.pc_out}, 32'h0e);
    chk("res_valid", {31'd0, bus.ir_valid}, 32'd0);
    bus.resume = 1'b0;
    tick();
    chk("res_rehalt", {31'd0, bus.halted}, 32'd1);
    chk("res_rehalt_pc", {24'd0, bus.pc_out}, 32'h0e);

    // jump out of HALTED, jump beats a coincident resume
    bus.jump_valid = 1'b1;
    bus.resume     = 1'b1;
    bus.jump_addr  = 8'h00;
    tick();
    chk("hj_halted", {31'd0, bus.halted}, 32'd0);
    chk("hj_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("hj_pc", {24'd0, bus.pc_out}, 32'h00);
    bus.jump_valid = 1'b0;
    bus.resume     = 1'b0;
    bus.ir_ready   = 1'b1;
    tick(); chk_issue("hj_tgt", 16'h7f00, 8'h00, 8'h01);
    tick(); chk_issue("hj_next", 16'h0100, 8'h01, 8'h02);

    // asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("ar_pc", {24'd0, bus.pc_out}, 32'h00);
    chk("ar_halted", {31'd0, bus.halted}, 32'd0);
    chk("ar_ir", {16'd0, bus.ir}, 32'h0000);
    tick();
    rst_n = 1'b1;
    tick(); chk_issue("ar_restart", 16'h7f00, 8'h00, 8'h01);

    // PC wrap with stub ROM
    stub           = 1'b1;
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'hff;
    tick();
    chk("w_bubble", {31'd0, bus.ir_valid}, 32'd0);
    chk("w_pc", {24'd0, bus.pc_out}, 32'hff);
    bus.jump_valid = 1'b0;
    tick(); chk_issue("w_ff", 16'h1234, 8'hff, 8'h00);
    tick(); chk_issue("w_00", 16'h1234, 8'h00, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
